mc_sequencer: RTL
=================

# mc_sequencer

Multicycle control sequencer for the ARMv4 subset processor (ADD/SUB/AND/ORR, LDR/STR, B). It replaces the single-cycle controller when the core moves to a shared instruction/data memory with a multicycle datapath. It steps each instruction through fetch, decode, execute, memory and writeback states and drives every datapath mux select and write enable. It owns the NZCV flag register and the condition check, and stalls on a memory-ready handshake.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low (0 = reset)
- Instr  in  20  instruction-register bits [31:12]
- ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle
- mem_ready  in  1  memory completed the access presented this cycle
- PCWrite  out  1  PC register enable
- IRWrite  out  1  instruction register enable
- AdrSrc  out  1  memory address select (0 = PC, 1 = ALU result register)
- MemWrite  out  1  data memory write enable
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A select (0 = RD1, 1 = PC)
- ALUSrcB  out  2  ALU B select (00 = RD2, 01 = ExtImm, 10 = constant 4)
- ResultSrc  out  2  result select (00 = ALUOut, 01 = Data, 10 = ALUResult)
- ImmSrc  out  2  extend mode (00 imm8, 01 imm12, 10 branch)
- RegSrc  out  2  register read address selects, same meaning as the single-cycle datapath
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- FETCH
  - Drives AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10.
  - When mem_ready=1: IRWrite=1, PCWrite=1, go to DECODE.
  - Otherwise hold in FETCH with IRWrite and PCWrite at 0.
- DECODE
  - Drives ALUSrcA=1, ALUSrcB=10 (produces PC+8 for R15 reads).
  - Captures CondEx into cond_q.
  - Op=01 goes to MEMADR. Op=00 goes to EXECI if Funct[5]=1, else EXECR. Op=10 goes to BRANCH. Op=11 returns to FETCH with no side effects.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALU ADD. Goes to MEMRD if L=Instr[20]=1, else MEMWR.
- MEMRD: AdrSrc=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegW=1, then FETCH.
- MEMWR: AdrSrc=1, MemW=1. Waits for mem_ready, then goes to FETCH.
- EXECR / EXECI: ALUSrcA=0, ALUSrcB=00 or 01, ALU decoded from Funct[4:1]. Go to ALUWB.
- ALUWB: ResultSrc=00, RegW=1, then FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ImmSrc=10, ResultSrc=10, Branch=1, then FETCH.
- Gating
  - RegWrite = RegW & cond_q & ~NoWrite.
  - MemWrite = MemW & cond_q.
  - Outside FETCH, PCWrite = cond_q & (Branch | (RegW & Rd==15)).
- Flags
  - Written at the end of EXECR/EXECI only.
  - NZ are written if S & cond_q.
  - CV are written if S & cond_q & (ADD|SUB).
- Unrecognised DP Funct[4:1]: ALUControl=00, FlagW=00, NoWrite=1, so the instruction has no architectural effect.
- Condition codes 0000–1110 follow the standard ARM table. Cond 1111 gives CondEx=0.

## Timing
- Reset
  - While reset=0 at a clock edge: state becomes FETCH, flags become 0000, cond_q becomes 0.
  - While reset is low, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0 combinationally.
  - Selects take their FETCH values.
  - Reset asserted mid-instruction aborts it; no writes occur in that cycle.
- Latency with zero wait states: B 3 cycles, DP 4, STR 4, LDR 5.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- In MEMWR, MemWrite stays asserted for every wait cycle.
- Outputs are Moore, decoded from state plus registered Instr and cond_q. The only Mealy exception is the mem_ready gating in FETCH.
- Flags updated in EXEC are visible to the condition check of the next instruction's DECODE.

## Configuration
- MC_CMP_EN defined:
  - Funct[4:1]=1010 decodes as CMP: ALUControl=01, FlagW=11 when S=1, NoWrite=1.
  - CMP always takes the full 4-cycle DP path.
- MC_CMP_EN undefined: 1010 is an unrecognised DP op (no effect).

## Structure
- Package mc_pkg holds:
  - the state enum;
  - ALUControl, ResultSrc, ALUSrcB and ImmSrc localparam encodings;
  - Op encodings (OP_DP, OP_MEM, OP_BR);
  - condition-code constants.
- Sub-module mc_condunit: flag register, condcheck and cond_q capture.
- The FSM and the ALU decode stay in mc_sequencer.

## Test plan
- Reset held low for 3 cycles with mem_ready=1: all enables stay 0. After release, the first FETCH asserts IRWrite and PCWrite in cycle 1.
- ADD R2,R0,#5 (E2802005) with mem_ready=1: states FETCH→DECODE→EXECI→ALUWB. RegWrite=1 only in ALUWB, ALUSrcB=01 in EXECI.
- SUBS R8,R7,R2 giving ALUFlags=0100, followed by BEQ: branch taken, PCWrite=1 in BRANCH.
- Same sequence with ALUFlags=0000: BEQ has PCWrite=0 in BRANCH, and the flags register reads 0000.
- STR with mem_ready=0 for 2 cycles in MEMWR: MemWrite held high 3 cycles. Return to FETCH the cycle after mem_ready=1.
- LDR R2,[R0,#96] with one FETCH wait state: 6 cycles total, ResultSrc=01 and RegWrite=1 in MEMWB.
- With MC_CMP_EN, CMP R1,R1 (E1510001): Z set, RegWrite=0 in ALUWB. Without MC_CMP_EN: flags unchanged, RegWrite=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle ARM control sequencer.
// MC_CMP_EN adds the CMP data-processing opcode.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_BR = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] FN_AND = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0010;
  localparam logic [3:0] FN_ADD = 4'b0100;
  localparam logic [3:0] FN_ORR = 4'b1100;
`ifdef MC_CMP_EN
  localparam logic [3:0] FN_CMP = 4'b1010;
`endif

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  function automatic logic cond_eval(
    input logic [3:0] cond,
    input logic [3:0] flags
  );
    logic n, z, c, v, r;
    {n, z, c, v} = flags;
    r = 1'b0;
    unique case (cond)
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_CS: r = c;
      COND_CC: r = ~c;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = c & ~z;
      COND_LS: r = ~c | z;
      COND_GE: r = ~(n ^ v);
      COND_LT: r = n ^ v;
      COND_GT: r = ~z & ~(n ^ v);
      COND_LE: r = z | (n ^ v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_condunit.sv
// NZCV flag register, condition check and per-instruction
// condition latch captured in DECODE.
module mc_condunit
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       capture,
  input  logic       exec,
  input  logic [1:0] flag_w,
  output logic       cond_q,
  output logic [3:0] flags_q
);

  logic       cond_ex;
  logic       cond_d;
  logic [3:0] flags_d;

  always_comb begin
    cond_ex = cond_eval(cond, flags_q);
    cond_d  = capture ? cond_ex : cond_q;
    flags_d = flags_q;
    if (exec && cond_q && flag_w[1])
      flags_d[3:2] = alu_flags[3:2];
    if (exec && cond_q && flag_w[0])
      flags_d[1:0] = alu_flags[1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cond_q  <= 1'b0;
      flags_q <= 4'b0000;
    end else begin
      cond_q  <= cond_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle FSM controller for the ARMv4 subset core.
// Optional CMP support is enabled by MC_CMP_EN.
module mc_sequencer
  import mc_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  input  logic         mem_ready,
  output logic         PCWrite,
  output logic         IRWrite,
  output logic         AdrSrc,
  output logic         MemWrite,
  output logic         RegWrite,
  output logic         ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ResultSrc,
  output logic [1:0]   ImmSrc,
  output logic [1:0]   RegSrc,
  output logic [1:0]   ALUControl
);

  state_e state_q, state_d;

  logic [1:0] op;
  logic [3:0] cmd;
  logic       s_bit;
  logic [3:0] rd;
  logic       unused_rn;

  assign op        = Instr[27:26];
  assign cmd       = Instr[24:21];
  assign s_bit     = Instr[20];
  assign rd        = Instr[15:12];
  assign unused_rn = ^Instr[19:16];

  logic [1:0] dp_alu;
  logic [1:0] dp_flag_w;
  logic       no_write;

  always_comb begin
    dp_alu    = ALU_ADD;
    dp_flag_w = 2'b00;
    no_write  = 1'b0;
    if (op == OP_DP) begin
      unique case (cmd)
        FN_ADD: begin
          dp_alu    = ALU_ADD;
          dp_flag_w = {s_bit, s_bit};
        end
        FN_SUB: begin
          dp_alu    = ALU_SUB;
          dp_flag_w = {s_bit, s_bit};
        end
        FN_AND: begin
          dp_alu    = ALU_AND;
          dp_flag_w = {s_bit, 1'b0};
        end
        FN_ORR: begin
          dp_alu    = ALU_ORR;
          dp_flag_w = {s_bit, 1'b0};
        end
`ifdef MC_CMP_EN
        FN_CMP: begin
          dp_alu    = ALU_SUB;
          dp_flag_w = {s_bit, s_bit};
          no_write  = 1'b1;
        end
`endif
        default: no_write = 1'b1;
      endcase
    end
  end

  always_comb begin
    unique case (op)
      OP_MEM:  ImmSrc = IMM_12;
      OP_BR:   ImmSrc = IMM_BR;
      default: ImmSrc = IMM_8;
    endcase
    RegSrc = {op == OP_MEM, op == OP_BR};
  end

  logic       fetch_pc, ir_w, adr, mem_w, reg_w, branch;
  logic       src_a;
  logic [1:0] src_b, res, alu;
  logic       exec, capture;

  always_comb begin
    state_d  = state_q;
    fetch_pc = 1'b0;
    ir_w     = 1'b0;
    adr      = 1'b0;
    mem_w    = 1'b0;
    reg_w    = 1'b0;
    branch   = 1'b0;
    src_a    = 1'b0;
    src_b    = SRCB_RD2;
    res      = RES_ALUOUT;
    alu      = ALU_ADD;
    unique case (state_q)
      S_FETCH: begin
        src_a = 1'b1;
        src_b = SRCB_FOUR;
        res   = RES_ALURES;
        if (mem_ready) begin
          ir_w     = 1'b1;
          fetch_pc = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        src_a = 1'b1;
        src_b = SRCB_FOUR;
        unique case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = Instr[25] ? S_EXECI : S_EXECR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        src_b   = SRCB_IMM;
        state_d = Instr[20] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        res     = RES_DATA;
        reg_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        adr   = 1'b1;
        mem_w = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu     = dp_alu;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        src_b   = SRCB_IMM;
        alu     = dp_alu;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        res     = RES_ALUOUT;
        reg_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        src_b   = SRCB_IMM;
        res     = RES_ALURES;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign exec    = (state_q == S_EXECR) || (state_q == S_EXECI);
  assign capture = (state_q == S_DECODE);

  logic       cond_q;
  logic [3:0] flags_q;

  mc_condunit u_cond (
    .clk       (clk),
    .reset     (reset),
    .cond      (Instr[31:28]),
    .alu_flags (ALUFlags),
    .capture   (capture),
    .exec      (exec),
    .flag_w    (dp_flag_w),
    .cond_q    (cond_q),
    .flags_q   (flags_q)
  );

  logic unused_flags;
  assign unused_flags = ^flags_q;

  // Reset kills every write and parks the selects on their fetch values
  always_comb begin
    AdrSrc     = adr;
    ALUSrcA    = src_a;
    ALUSrcB    = src_b;
    ResultSrc  = res;
    ALUControl = alu;
    if (!reset) begin
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b1;
      ALUSrcB    = SRCB_FOUR;
      ResultSrc  = RES_ALURES;
      ALUControl = ALU_ADD;
    end
    PCWrite  = reset & (fetch_pc |
               (cond_q & (branch | (reg_w & (rd == 4'd15)))));
    IRWrite  = reset & ir_w;
    MemWrite = reset & mem_w & cond_q;
    RegWrite = reset & reg_w & cond_q & ~no_write;
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

endmodule
